// File: rtl/framebuffer_writer.sv
// Pixel sink for the shared VGA draw bus: queues on-screen pixels in a FIFO and
// streams them into the frame-buffer RAM through a ready/valid write port.
// A clear request replaces the queue contents with a full-screen colour sweep.
module framebuffer_writer #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        vga_draw_enable_bus,
    input  logic [7:0]  vga_x_out_bus,
    input  logic [7:0]  vga_y_out_bus,
    input  logic [23:0] vga_RGB_out_bus,
    input  logic        clear,
    input  logic        mem_ready,
    output logic        mem_wren,
    output logic [14:0] mem_address,
    output logic [23:0] mem_data,
    output logic        busy,
    output logic        clear_done,
    output logic        overflow,
    output logic        off_screen
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W   = 15 + 24;
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e             state_q, state_d;
    logic [14:0]        sweep_q, sweep_d;
    logic               wren_q, wren_d;
    logic [14:0]        addr_q, addr_d;
    logic [23:0]        data_q, data_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               offs_q, offs_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

    logic               in_range;
    logic [14:0]        pix_addr;
    logic               push, pop, flush, accept, load, full;
    logic [PTR_W-1:0]   wr_base, rd_base;
    logic [PTR_W:0]     cnt_base;

    // Address y*160+x as shifts; cannot exceed 15 bits for on-screen pixels.
    assign in_range = (32'(vga_x_out_bus) < SCREEN_W) && (32'(vga_y_out_bus) < SCREEN_H);
    assign pix_addr = (15'(vga_y_out_bus) << 7) + (15'(vga_y_out_bus) << 5)
                    + 15'(vga_x_out_bus);

    // Next-state: FSM, output register, FIFO pointers and sticky flags.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        offs_d  = offs_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        accept  = wren_q && mem_ready;
        load    = !wren_q || mem_ready;

        unique case (state_q)
            S_IDLE: begin
                if (clear) begin
                    // Drop queue and any unaccepted write; sweep starts next cycle.
                    flush   = 1'b1;
                    state_d = S_CLEAR;
                    sweep_d = '0;
                    wren_d  = 1'b1;
                    addr_d  = '0;
                    data_d  = CLEAR_COLOR;
                    ovf_d   = 1'b0;
                    offs_d  = 1'b0;
                end else if (load) begin
                    if (count_q != '0) begin
                        pop              = 1'b1;
                        wren_d           = 1'b1;
                        {addr_d, data_d} = fifo_mem[rd_ptr_q];
                    end else begin
                        wren_d = 1'b0;
                    end
                end
            end
            S_CLEAR: begin
                if (accept) begin
                    if (sweep_q == LAST_ADDR) begin
                        wren_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        sweep_d = sweep_q + 15'd1;
                        addr_d  = sweep_q + 15'd1;
                        data_d  = CLEAR_COLOR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A same-cycle pixel lands in the freshly flushed queue.
        wr_base  = flush ? '0 : wr_ptr_q;
        rd_base  = flush ? '0 : rd_ptr_q;
        cnt_base = flush ? '0 : count_q;
        full     = (32'(cnt_base) == FIFO_DEPTH);

        if (vga_draw_enable_bus) begin
            if (!in_range) begin
                offs_d = 1'b1;
            end else if (full) begin
                ovf_d = 1'b1;
            end else begin
                push = 1'b1;
            end
        end

        wr_ptr_d = push ? wr_base + 1'b1 : wr_base;
        rd_ptr_d = pop ? rd_base + 1'b1 : rd_base;
        count_d  = cnt_base + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            sweep_q  <= '0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            offs_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            offs_q   <= offs_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; needs no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_base] <= {pix_addr, vga_RGB_out_bus};
        end
    end

    assign mem_wren    = wren_q;
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign clear_done  = done_q;
    assign overflow    = ovf_q;
    assign off_screen  = offs_q;
    assign busy        = (state_q == S_CLEAR) || (count_q != '0) || wren_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed bench for framebuffer_writer: accepted writes are logged and
// compared with hand-computed addresses, data and timing.
module tb_framebuffer_writer;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [23:0] rgb;
    logic        clear;
    logic        mem_ready;
    logic        mem_wren;
    logic [14:0] mem_address;
    logic [23:0] mem_data;
    logic        busy;
    logic        clear_done;
    logic        overflow;
    logic        off_screen;

    int n_checks = 0;
    int n_fail   = 0;

    logic [38:0] wlog [$];

    framebuffer_writer dut (
        .clk                 (clk),
        .resetn              (resetn),
        .vga_draw_enable_bus (en),
        .vga_x_out_bus       (x),
        .vga_y_out_bus       (y),
        .vga_RGB_out_bus     (rgb),
        .clear               (clear),
        .mem_ready           (mem_ready),
        .mem_wren            (mem_wren),
        .mem_address         (mem_address),
        .mem_data            (mem_data),
        .busy                (busy),
        .clear_done          (clear_done),
        .overflow            (overflow),
        .off_screen          (off_screen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every accepted write.
    always @(posedge clk) begin
        if (resetn && mem_wren && mem_ready) wlog.push_back({mem_address, mem_data});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_px(input logic e, input int xi, input int yi, input logic [23:0] c);
        en  = e;
        x   = 8'(xi);
        y   = 8'(yi);
        rgb = c;
    endtask

    initial begin
        int bad;
        int idx;
        int done_cnt;
        int done_at;

        resetn = 1'b0;
        set_px(1'b0, 0, 0, 24'h0);
        clear     = 1'b0;
        mem_ready = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // Reset state
        check("rst_wren", 64'(mem_wren), 64'd0);
        check("rst_addr", 64'(mem_address), 64'd0);
        check("rst_data", 64'(mem_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(clear_done), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_offs", 64'(off_screen), 64'd0);

        // Single pixel: 5*160+10 = 810, visible two cycles later
        wlog.delete();
        set_px(1'b1, 10, 5, 24'hFF0000);
        tick();
        set_px(1'b0, 0, 0, 24'h0);
        check("px_n1_wren", 64'(mem_wren), 64'd0);
        tick();
        check("px_n2_wren", 64'(mem_wren), 64'd1);
        check("px_n2_addr", 64'(mem_address), 64'd810);
        check("px_n2_data", 64'(mem_data), 64'hFF0000);
        tick();
        check("px_n3_wren", 64'(mem_wren), 64'd0);
        check("px_n3_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("px_nwrites", 64'(wlog.size()), 64'd1);

        // Off-screen drops, then bottom-right corner
        wlog.delete();
        set_px(1'b1, 160, 0, 24'hAAAAAA);
        tick();
        set_px(1'b1, 0, 120, 24'hBBBBBB);
        tick();
        set_px(1'b1, 159, 119, 24'h123456);
        tick();
        set_px(1'b0, 0, 0, 24'h0);
        repeat (4) tick();
        check("offs_nwrites", 64'(wlog.size()), 64'd1);
        check("offs_entry", 64'(wlog[0]), 64'({15'd19199, 24'h123456}));
        check("offs_flag", 64'(off_screen), 64'd1);
        check("offs_ovf", 64'(overflow), 64'd0);

        // Back-pressure: 16 in FIFO + 1 in output register, 18th dropped
        wlog.delete();
        mem_ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            set_px(1'b1, k, 0, 24'h0A0000 | 24'(k));
            tick();
        end
        set_px(1'b0, 0, 0, 24'h0);
        tick();
        check("bp_ovf", 64'(overflow), 64'd1);
        check("bp_wren", 64'(mem_wren), 64'd1);
        check("bp_addr", 64'(mem_address), 64'd0);
        check("bp_data", 64'(mem_data), 64'h0A0000);
        repeat (2) tick();
        check("bp_addr_hold", 64'(mem_address), 64'd0);
        check("bp_data_hold", 64'(mem_data), 64'h0A0000);
        check("bp_busy", 64'(busy), 64'd1);
        mem_ready = 1'b1;
        repeat (20) tick();
        check("bp_nwrites", 64'(wlog.size()), 64'd17);
        for (int k = 0; k < 17; k++) begin
            check($sformatf("bp_entry%0d", k), 64'(wlog[k]),
                  64'({15'(k), 24'h0A0000 | 24'(k)}));
        end
        check("bp_busy_end", 64'(busy), 64'd0);

        // Clear with three stalled pixels and a same-cycle survivor
        wlog.delete();
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_px(1'b1, 20 + k, 3, 24'h777777);
            tick();
        end
        clear = 1'b1;
        set_px(1'b1, 1, 0, 24'h00FF00);
        tick();
        clear = 1'b0;
        set_px(1'b0, 0, 0, 24'h0);
        mem_ready = 1'b1;
        check("clr_first_wren", 64'(mem_wren), 64'd1);
        check("clr_first_addr", 64'(mem_address), 64'd0);
        check("clr_first_data", 64'(mem_data), 64'h000000);
        check("clr_flag_offs", 64'(off_screen), 64'd0);
        check("clr_flag_ovf", 64'(overflow), 64'd0);
        done_cnt = 0;
        done_at  = 0;
        for (int j = 2; j <= 19205; j++) begin
            tick();
            if (clear_done) begin
                done_cnt++;
                if (done_at == 0) done_at = j;
            end
        end
        check("clr_done_pulses", 64'(done_cnt), 64'd1);
        check("clr_done_cycle", 64'(done_at), 64'd19201);
        check("clr_nwrites", 64'(wlog.size()), 64'd19201);
        bad = 0;
        for (int a = 0; a < 19200 && a < wlog.size(); a++) begin
            if (wlog[a] !== {15'(a), 24'h000000}) bad++;
        end
        check("clr_sweep_bad", 64'(bad), 64'd0);
        check("clr_survivor", 64'(wlog[19200]), 64'({15'd1, 24'h00FF00}));
        check("clr_busy_end", 64'(busy), 64'd0);

        // Full raster including one off-screen column and row
        wlog.delete();
        for (int yi = 0; yi <= 120; yi++) begin
            for (int xi = 0; xi <= 160; xi++) begin
                set_px(1'b1, xi, yi, {8'(xi), 8'(yi), 8'h5A});
                tick();
            end
        end
        set_px(1'b0, 0, 0, 24'h0);
        repeat (5) tick();
        check("map_nwrites", 64'(wlog.size()), 64'd19200);
        bad = 0;
        idx = 0;
        for (int yi = 0; yi < 120; yi++) begin
            for (int xi = 0; xi < 160; xi++) begin
                if (idx < wlog.size() &&
                    wlog[idx] !== {15'(yi * 160 + xi), 8'(xi), 8'(yi), 8'h5A}) bad++;
                idx++;
            end
        end
        check("map_bad", 64'(bad), 64'd0);
        check("map_offs", 64'(off_screen), 64'd1);
        check("map_ovf", 64'(overflow), 64'd0);

        // Reset in the middle of a sweep
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (4999) tick();
        check("mid_addr", 64'(mem_address), 64'd4999);
        check("mid_wren", 64'(mem_wren), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_wren", 64'(mem_wren), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        wlog.delete();
        repeat (3) tick();
        resetn = 1'b1;
        repeat (5) tick();
        check("mid_nwrites", 64'(wlog.size()), 64'd0);
        check("mid_idle_wren", 64'(mem_wren), 64'd0);
        set_px(1'b1, 3, 2, 24'hABCDEF);
        tick();
        set_px(1'b0, 0, 0, 24'h0);
        check("post_n1_wren", 64'(mem_wren), 64'd0);
        tick();
        check("post_n2_wren", 64'(mem_wren), 64'd1);
        check("post_n2_addr", 64'(mem_address), 64'd323);
        check("post_n2_data", 64'(mem_data), 64'hABCDEF);
        repeat (3) tick();
        check("post_nwrites", 64'(wlog.size()), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
